// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for a single-write-port register file: round-robin
// arbitration between the ALU (A) and load unit (B), plus a pending-bit scoreboard.
module regfile_wb_sched #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  input  logic            iss_valid,
  output logic            iss_stall,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_in,
  output logic [31:0]     pending
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_in_q, rf_in_d;
  logic [31:0]       pending_q, pending_d;
  logic              stall;
  logic              alloc;

  always_comb begin
    stall     = iss_valid & (pending_q[iss_rs1] | pending_q[iss_rs2] | pending_q[iss_rd]);
    alloc     = iss_valid & ~stall & (iss_rd != 5'd0);
    iss_stall = stall;
  end

  // On a conflict the requester that did not win last time gets the port.
  always_comb begin
    a_ready      = a_valid & (~b_valid | (last_grant_q == GRANT_B));
    b_ready      = b_valid & (~a_valid | (last_grant_q == GRANT_A));
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_in_d      = rf_in_q;
    if (a_ready) begin
      last_grant_d = GRANT_A;
      rf_we_d      = (a_rd != 5'd0);
      rf_rd_d      = a_rd;
      rf_in_d      = a_data;
    end else if (b_ready) begin
      last_grant_d = GRANT_B;
      rf_we_d      = (b_rd != 5'd0);
      rf_rd_d      = b_rd;
      rf_in_d      = b_data;
    end
  end

  // Clear is applied before set so an allocation on the same edge wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_rd_q] = 1'b0;
    if (alloc)   pending_d[iss_rd]  = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GRANT_B;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_in_q      <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_in_q      <= rf_in_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    rf_we   = rf_we_q;
    rf_rd   = rf_rd_q;
    rf_in   = rf_in_q;
    pending = pending_q;
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of arbitration, write port and scoreboard.
module tb_regfile_wb_sched;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [4:0]      iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic            iss_valid = 1'b0;
  logic            iss_stall;
  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]      a_rd = '0, b_rd = '0;
  logic [XLEN-1:0] a_data = '0, b_data = '0;
  logic            a_ready, b_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_in;
  logic [31:0]     pending;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_sched #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_valid(iss_valid), .iss_stall(iss_stall),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_in(rf_in), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]     m_pend;
  logic            m_last_a;
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_in;

  function automatic logic m_stall();
    return iss_valid && (m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
  endfunction

  function automatic logic m_grant_a();
    return a_valid && (!b_valid || !m_last_a);
  endfunction

  function automatic logic m_grant_b();
    return b_valid && (!a_valid || m_last_a);
  endfunction

  task automatic drive_idle();
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  // Advance one clock, applying the model rules to the inputs seen before the edge.
  task automatic tick();
    logic [31:0] np;
    logic ga, gb;
    ga = m_grant_a();
    gb = m_grant_b();
    np = m_pend;
    if (m_we) np[m_rd] = 1'b0;
    if (iss_valid && !m_stall() && iss_rd != 5'd0) np[iss_rd] = 1'b1;
    @(posedge clk);
    m_pend = np;
    if (ga) begin
      m_we = (a_rd != 5'd0); m_rd = a_rd; m_in = a_data; m_last_a = 1'b1;
    end else if (gb) begin
      m_we = (b_rd != 5'd0); m_rd = b_rd; m_in = b_data; m_last_a = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive_idle();
    m_pend = '0; m_last_a = 1'b0; m_we = 1'b0; m_rd = '0; m_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL reset_pending got %h exp %h", pending, 32'h0); end
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
    n_cmp++; if (rf_rd !== 5'd0 || rf_in !== '0) begin n_bad++; $display("FAIL reset_rf got rd=%0d in=%h exp 0/0", rf_rd, rf_in); end
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h11;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL first_a_ready got %b exp 1", a_ready); end
    tick();
    drive_idle();
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_in !== 64'h11)
      begin n_bad++; $display("FAIL first_write got we=%b rd=%0d in=%h exp 1/5/11", rf_we, rf_rd, rf_in); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL first_write_drop got %b exp 0", rf_we); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_rd;
    apply_reset();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 64'hA1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 64'hB2;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) drive_idle();
      #1;
      if (i < 4) begin
        n_cmp++; if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1))
          begin n_bad++; $display("FAIL rr_grant[%0d] got a=%b b=%b exp a=%b b=%b", i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1)); end
      end
      if (i > 0) begin
        exp_rd = ((i - 1) % 2 == 0) ? 5'd1 : 5'd2;
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== exp_rd)
          begin n_bad++; $display("FAIL rr_write[%0d] got we=%b rd=%0d exp 1/%0d", i, rf_we, rf_rd, exp_rd); end
      end
      tick();
    end
  endtask

  task automatic test_raw();
    apply_reset();
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL raw_alloc_stall got %b exp 0", iss_stall); end
    tick();
    iss_rd = 5'd8; iss_rs1 = 5'd7;
    #1;
    n_cmp++; if (pending[7] !== 1'b1) begin n_bad++; $display("FAIL raw_pending7 got %b exp 1", pending[7]); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (iss_stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall_wait[%0d] got %b exp 1", i, iss_stall); end
      tick();
    end
    b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h7777;
    #1;
    n_cmp++; if (b_ready !== 1'b1 || iss_stall !== 1'b1) begin n_bad++; $display("FAIL raw_b_grant got ready=%b stall=%b exp 1/1", b_ready, iss_stall); end
    tick();
    b_valid = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || iss_stall !== 1'b1)
      begin n_bad++; $display("FAIL raw_write got we=%b rd=%0d stall=%b exp 1/7/1", rf_we, rf_rd, iss_stall); end
    tick();
    iss_valid = 1'b0;
    iss_valid = 1'b1;
    #1;
    n_cmp++; if (iss_stall !== 1'b0 || pending[7] !== 1'b0)
      begin n_bad++; $display("FAIL raw_release got stall=%b p7=%b exp 0/0", iss_stall, pending[7]); end
    iss_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    apply_reset();
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_bad++; $display("FAIL x0_stall got %b exp 0", iss_stall); end
    tick();
    iss_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 64'hFF;
    #1;
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL x0_pending got %h exp 0", pending); end
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL x0_b_ready got %b exp 1", b_ready); end
    tick();
    b_valid = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_rf_we got %b exp 0", rf_we); end
    // The rd=0 grant counts as B's turn, so A wins the next conflict.
    a_valid = 1'b1; a_rd = 5'd3; b_valid = 1'b1; b_rd = 5'd4; b_data = 64'hFF;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_bad++; $display("FAIL x0_last_grant got a=%b b=%b exp 1/0", a_ready, b_ready); end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_set_clear();
    apply_reset();
    b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h99;
    tick();
    b_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || iss_stall !== 1'b0)
      begin n_bad++; $display("FAIL setclr_pre got we=%b rd=%0d stall=%b exp 1/9/0", rf_we, rf_rd, iss_stall); end
    tick();
    iss_valid = 1'b0;
    #1;
    n_cmp++; if (pending[9] !== 1'b1) begin n_bad++; $display("FAIL setclr_pending9 got %b exp 1", pending[9]); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    iss_valid = 1'b1; iss_rd = 5'd2;
    tick();
    iss_rd = 5'd8;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33;
    tick();
    drive_idle();
    #1;
    n_cmp++; if (pending !== 32'h0000_0104 || rf_we !== 1'b1)
      begin n_bad++; $display("FAIL arst_pre got pend=%h we=%b exp 00000104/1", pending, rf_we); end
    reset = 1'b0;
    #1;
    n_cmp++; if (pending !== 32'h0 || rf_we !== 1'b0)
      begin n_bad++; $display("FAIL arst_now got pend=%h we=%b exp 0/0", pending, rf_we); end
    m_pend = '0; m_last_a = 1'b0; m_we = 1'b0; m_rd = '0; m_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic ga, gb;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rs1 = 5'($urandom_range(0, 7));
      iss_rs2 = 5'($urandom_range(0, 7));
      iss_rd  = 5'($urandom_range(0, 7));
      #1;
      n_cmp++; if (a_ready !== m_grant_a() || b_ready !== m_grant_b())
        begin n_bad++; $display("FAIL rnd_grant[%0d] got a=%b b=%b exp a=%b b=%b", cyc, a_ready, b_ready, m_grant_a(), m_grant_b()); end
      n_cmp++; if (iss_stall !== m_stall())
        begin n_bad++; $display("FAIL rnd_stall[%0d] got %b exp %b", cyc, iss_stall, m_stall()); end
      n_cmp++; if (pending !== m_pend)
        begin n_bad++; $display("FAIL rnd_pending[%0d] got %h exp %h", cyc, pending, m_pend); end
      n_cmp++; if (rf_we !== m_we || (m_we && (rf_rd !== m_rd || rf_in !== m_in)))
        begin n_bad++; $display("FAIL rnd_write[%0d] got we=%b rd=%0d in=%h exp we=%b rd=%0d in=%h", cyc, rf_we, rf_rd, rf_in, m_we, m_rd, m_in); end
      ga = m_grant_a();
      gb = m_grant_b();
      tick();
      // Requesters keep their offer stable until it is taken.
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd    = 5'($urandom_range(0, 7));
        a_data  = {$urandom, $urandom};
      end
      if (!b_valid || gb) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_rd    = 5'($urandom_range(0, 7));
        b_data  = {$urandom, $urandom};
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_raw();
    test_x0();
    test_set_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Writeback scheduler and scoreboard for the single-write-port 64-bit, 32-entry integer register file.
- Shares the one write port between two writeback requesters: A (ALU pipe) and B (load/memory unit), using round-robin arbitration.
- Drives the register file write port from registered outputs.
- Tracks in-flight destinations in a pending-bit scoreboard so issue can stall on RAW/WAW hazards.

Parameters:
- XLEN, 64, data width of writeback values and the register file port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- iss_rs1  input  5  source register 1 of the instruction at issue.
- iss_rs2  input  5  source register 2 of the instruction at issue.
- iss_rd  input  5  destination register of the instruction at issue.
- iss_valid  input  1  issue stage holds a valid instruction that writes iss_rd.
- iss_stall  output  1  combinational; hazard on rs1/rs2/rd.
- a_valid  input  1  requester A has a writeback.
- a_rd  input  5  destination for A.
- a_data  input  XLEN  data for A.
- a_ready  output  1  A granted this cycle.
- b_valid  input  1  requester B has a writeback.
- b_rd  input  5  destination for B.
- b_data  input  XLEN  data for B.
- b_ready  output  1  B granted this cycle.
- rf_we  output  1  register file write enable (registered).
- rf_rd  output  5  register file write index (registered).
- rf_in  output  XLEN  register file write data (registered).
- pending  output  32  scoreboard bits; bit 0 is always 0.

Behaviour:
- Reset (reset=0, async):
  - pending=0, rf_we=0, rf_rd=0, rf_in=0.
  - last_grant=B, so A wins the first conflict.
  - Reset mid-transfer discards any granted-but-not-written data.
- Scoreboard:
  - iss_stall = iss_valid & (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd]).
  - Index 0 never stalls.
  - Allocate: iss_valid & ~iss_stall & iss_rd!=0 sets pending[iss_rd] at the next edge.
  - Clear: pending[rf_rd] is cleared at the edge following a cycle with rf_we=1.
  - Same-edge set and clear of the same index: set wins.
- Arbitration (combinational grant, one per cycle):
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates on every grant.
  - ready never asserts without the matching valid.
  - A handshake completes in the cycle with valid & ready.
  - A requester holds valid, rd and data stable until ready.
- Write port:
  - The granted rd/data are registered into rf_rd/rf_in.
  - rf_we=1 at the next edge if rd!=0; otherwise rf_we=0.
  - With no grant, rf_we=0 and rf_rd/rf_in hold their values.
  - Latency is 1 cycle from handshake to rf_we; throughput is one write per cycle.
- rd=0 writebacks:
  - Accepted and handshaken, consuming a grant slot and updating last_grant.
  - Never written and never affect pending.
- The WAW stall guarantees at most one in-flight write per register. A/B ordering to distinct registers is unconstrained.
- A writeback to a register that is not pending is legal: it is written and pending stays 0.

Test Plan:
- Reset release: pending=0, rf_we=0. a_valid=1, a_rd=5, a_data=0x11 -> a_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_in=0x11.
- Conflict round-robin: both valid for 4 cycles (A rd=1, B rd=2, data held, each requester re-presents after its grant) -> grants A,B,A,B; rf_rd sequence 1,2,1,2, each one cycle after its grant.
- Scoreboard RAW: issue iss_rd=7 (allocated) -> pending[7]=1. Next instruction iss_rs1=7 -> iss_stall=1 until the cycle after B writes rd=7 (rf_we=1, rf_rd=7), then iss_stall=0.
- x0 handling: iss_rd=0 with iss_valid -> pending stays 0, no stall. b_valid with b_rd=0, data 0xFF -> b_ready=1, rf_we stays 0.
- Set/clear collision: rf_we=1, rf_rd=9 in the same cycle as an allocation of iss_rd=9 -> pending[9]=1 afterward.
- Async reset mid-op: pending=0x0000_0104, reset asserted between edges -> pending=0, rf_we=0 immediately, before any clock edge.
